// File: rtl/ir_diag_pkg.sv
// Shared definitions for the IR diagnostic-bus initiator: bus widths,
// the 13X read subfunction codes and the sequencer state encoding.
package ir_diag_pkg;

    localparam int DIAG_W       = 3;
    localparam int EBUS_SLICE_W = 6;
    localparam int SNAP_W       = 48;

    // Read subfunction codes placed on diag[4:6] during a 13X read.
    localparam logic [DIAG_W-1:0] READ_NORM_DRADR = 3'd0;
    localparam logic [DIAG_W-1:0] READ_JUMP_DRADR = 3'd1;
    localparam logic [DIAG_W-1:0] READ_AC_BLOCKS  = 3'd2;
    localparam logic [DIAG_W-1:0] READ_DISP_DRADR = 3'd3;
    localparam logic [DIAG_W-1:0] READ_IR_FIELDS  = 3'd4;
    localparam logic [DIAG_W-1:0] READ_EA_DRADR   = 3'd5;
    localparam logic [DIAG_W-1:0] READ_CARRY_BITS = 3'd6;
    localparam logic [DIAG_W-1:0] READ_ADCARRY    = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        RSETUP,
        RSTROBE,
        RGAP,
        LSETUP,
        LSTROBE,
        DONE
    } state_t;

endpackage

// File: rtl/ir_diag_master.sv
// Diagnostic-bus initiator for the IR board. Issues a single 06X load
// strobe, or sweeps all eight 13X read subfunctions into a 48-bit snapshot.
//
// Request handshake: start is a request that is accepted only on an edge
// where the sequencer is idle (busy low); while busy is high start is
// ignored and nothing is queued. done pulses for one cycle at the end of
// the accepted operation, and the idle cycle that follows accepts again.
//
// The IR numbers its buses MSB-first (diag[4:6], EBUS[0:5]); here the
// vectors are [2:0] and [5:0], so IR bit 0 is the MSB of each vector and
// EBUS lands in a snapshot field without reordering.
module ir_diag_master
    import ir_diag_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int STROBE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    opLoad,
    input  logic [DIAG_W-1:0]       loadSel,
    output logic                    busy,
    output logic                    done,
    output logic                    noResp,
    output logic [SNAP_W-1:0]       snapshot,
    output logic [DIAG_W-1:0]       diag,
    output logic                    diagLoadFunc06X,
    output logic                    diagReadFunc13X,
    input  logic                    drivingEBUS,
    input  logic [EBUS_SLICE_W-1:0] EBUS
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE - 1);

    state_t                  state, state_nx;
    logic [DIAG_W-1:0]       sub, sub_nx;
    logic [3:0]              tmr, tmr_nx;
    logic [DIAG_W-1:0]       diag_nx;
    logic [SNAP_W-1:0]       snap_nx;
    logic                    no_resp_nx;
    logic                    load_nx;
    logic                    read_nx;
    logic                    busy_nx;
    logic                    done_nx;

    // Next-state, counters and next values of every registered output.
    // Outputs are computed for the state being entered so they change only
    // on clock edges and line up with the state register.
    always_comb begin
        state_nx   = state;
        sub_nx     = sub;
        tmr_nx     = tmr;
        diag_nx    = diag;
        snap_nx    = snapshot;
        no_resp_nx = noResp;
        load_nx    = 1'b0;
        read_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    no_resp_nx = 1'b0;
                    if (opLoad) begin
                        // diag itself holds the captured load subfunction
                        diag_nx  = loadSel;
                        state_nx = LSETUP;
                    end else begin
                        sub_nx   = READ_NORM_DRADR;
                        diag_nx  = READ_NORM_DRADR;
                        state_nx = RSETUP;
                    end
                end
            end
            RSETUP: begin
                tmr_nx   = SETTLE_LAST;
                read_nx  = 1'b1;
                state_nx = RSTROBE;
            end
            RSTROBE: begin
                if (tmr == 4'd0) begin
                    // EBUS is only trusted on the last edge of the read window
                    if (drivingEBUS) begin
                        snap_nx[sub*EBUS_SLICE_W +: EBUS_SLICE_W] = EBUS;
                    end else begin
                        snap_nx[sub*EBUS_SLICE_W +: EBUS_SLICE_W] = '0;
                        no_resp_nx = 1'b1;
                    end
                    state_nx = RGAP;
                end else begin
                    tmr_nx  = tmr - 4'd1;
                    read_nx = 1'b1;
                end
            end
            RGAP: begin
                if (sub == READ_ADCARRY) begin
                    state_nx = DONE;
                end else begin
                    sub_nx   = sub + 3'd1;
                    diag_nx  = sub + 3'd1;
                    state_nx = RSETUP;
                end
            end
            LSETUP: begin
                tmr_nx   = STROBE_LAST;
                load_nx  = 1'b1;
                state_nx = LSTROBE;
            end
            LSTROBE: begin
                if (tmr == 4'd0) begin
                    state_nx = DONE;
                end else begin
                    tmr_nx  = tmr - 4'd1;
                    load_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    // State, counters and registered outputs; reset returns everything to
    // idle immediately, even mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sub             <= '0;
            tmr             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            noResp          <= 1'b0;
            snapshot        <= '0;
            diag            <= '0;
            diagLoadFunc06X <= 1'b0;
            diagReadFunc13X <= 1'b0;
        end else begin
            state           <= state_nx;
            sub             <= sub_nx;
            tmr             <= tmr_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            noResp          <= no_resp_nx;
            snapshot        <= snap_nx;
            diag            <= diag_nx;
            diagLoadFunc06X <= load_nx;
            diagReadFunc13X <= read_nx;
        end
    end

endmodule

// File: tb/tb_ir_diag_master.sv
// Bench for ir_diag_master: a cycle-indexed behavioural model of each
// operation, a per-cycle compare process with protocol checks, directed
// scenarios and a randomized operation loop.
module tb_ir_diag_master;

    localparam int SETTLE    = 2;
    localparam int STROBE    = 3;
    localparam int PER       = SETTLE + 2;
    localparam int SWEEP_LEN = 8 * PER + 1;
    localparam int LOAD_LEN  = STROBE + 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        opLoad;
    logic [2:0]  loadSel;
    logic        busy;
    logic        done;
    logic        noResp;
    logic [47:0] snapshot;
    logic [2:0]  diag;
    logic        diagLoadFunc06X;
    logic        diagReadFunc13X;
    logic        drivingEBUS;
    logic [5:0]  EBUS;

    int n_checks = 0;
    int n_errors = 0;

    // IR data the bench wants returned for the next accepted sweep
    logic [5:0] cur_data [8];
    logic       cur_drive[8];

    // Behavioural model: which operation runs and how many cycles since E0
    logic        m_active    = 1'b0;
    logic        m_load      = 1'b0;
    int          m_k         = 0;
    logic [2:0]  m_sel       = 3'd0;
    logic [47:0] m_snap      = 48'd0;
    logic        m_noresp    = 1'b0;
    logic [2:0]  m_diag_hold = 3'd0;
    logic [5:0]  m_data [8];
    logic        m_drive[8];

    logic        exp_busy, exp_done, exp_ld, exp_rd, exp_nr;
    logic [2:0]  exp_diag;
    logic [47:0] exp_snap;
    logic        prev_ld = 1'b0;
    logic        prev_rd = 1'b0;
    logic [2:0]  prev_diag = 3'd0;

    ir_diag_master #(
        .SETTLE(SETTLE),
        .STROBE(STROBE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .opLoad          (opLoad),
        .loadSel         (loadSel),
        .busy            (busy),
        .done            (done),
        .noResp          (noResp),
        .snapshot        (snapshot),
        .diag            (diag),
        .diagLoadFunc06X (diagLoadFunc06X),
        .diagReadFunc13X (diagReadFunc13X),
        .drivingEBUS     (drivingEBUS),
        .EBUS            (EBUS)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // snapshot after the first ncomp subfunctions of the running sweep
    function automatic logic [47:0] mix(input int ncomp);
        logic [47:0] r;
        r = m_snap;
        for (int j = 0; j < 8; j++)
            if (j < ncomp) r[j*6 +: 6] = m_drive[j] ? m_data[j] : 6'd0;
        return r;
    endfunction

    function automatic logic nr(input int ncomp);
        logic r;
        r = 1'b0;
        for (int j = 0; j < 8; j++)
            if (j < ncomp && !m_drive[j]) r = 1'b1;
        return r;
    endfunction

    // model update on each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active    <= 1'b0;
            m_load      <= 1'b0;
            m_k         <= 0;
            m_sel       <= 3'd0;
            m_snap      <= 48'd0;
            m_noresp    <= 1'b0;
            m_diag_hold <= 3'd0;
        end else if (m_active) begin
            if (m_k == (m_load ? LOAD_LEN : SWEEP_LEN)) begin
                m_active <= 1'b0;
                m_k      <= 0;
                if (m_load) begin
                    m_diag_hold <= m_sel;
                end else begin
                    m_snap      <= mix(8);
                    m_noresp    <= nr(8);
                    m_diag_hold <= 3'd7;
                end
            end else begin
                m_k <= m_k + 1;
            end
        end else if (start) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_load   <= opLoad;
            m_sel    <= loadSel;
            m_noresp <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                m_data[j]  <= cur_data[j];
                m_drive[j] <= cur_drive[j];
            end
        end
    end

    // compare, protocol checks, and IR responder stimulus for the next edge
    always @(negedge clk) begin : compare
        int i;
        int p;
        int nc;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_ld   = 1'b0;
        exp_rd   = 1'b0;
        exp_diag = m_diag_hold;
        exp_snap = m_snap;
        exp_nr   = m_noresp;
        if (m_active && m_load) begin
            exp_busy = 1'b1;
            exp_diag = m_sel;
            exp_ld   = (m_k >= 2 && m_k <= STROBE + 1);
            exp_done = (m_k == LOAD_LEN);
            exp_nr   = 1'b0;
        end else if (m_active) begin
            exp_busy = 1'b1;
            nc = m_k / PER;
            if (nc > 8) nc = 8;
            exp_snap = mix(nc);
            exp_nr   = nr(nc);
            if (m_k == SWEEP_LEN) begin
                exp_done = 1'b1;
                exp_diag = 3'd7;
            end else begin
                i = (m_k - 1) / PER;
                p = (m_k - 1) % PER;
                exp_diag = 3'(i);
                exp_rd   = (p >= 1 && p <= SETTLE);
            end
        end
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        chk("noResp", 64'(noResp), 64'(exp_nr));
        chk("diag", 64'(diag), 64'(exp_diag));
        chk("snapshot", 64'(snapshot), 64'(exp_snap));
        chk("load_strobe", 64'(diagLoadFunc06X), 64'(exp_ld));
        chk("read_strobe", 64'(diagReadFunc13X), 64'(exp_rd));

        chk("strobe_exclusive", 64'(diagLoadFunc06X & diagReadFunc13X), 64'd0);
        if ((diagLoadFunc06X || diagReadFunc13X) && (prev_ld || prev_rd))
            chk("diag_stable", 64'(diag), 64'(prev_diag));
        if ((diagLoadFunc06X && !prev_ld) || (diagReadFunc13X && !prev_rd))
            chk("idle_before_strobe", 64'({prev_ld, prev_rd}), 64'd0);
        prev_ld   = diagLoadFunc06X;
        prev_rd   = diagReadFunc13X;
        prev_diag = diag;

        // valid data only in the last read-window cycle; garbage otherwise
        if (m_active && !m_load && m_k < SWEEP_LEN && ((m_k - 1) % PER) == SETTLE) begin
            EBUS        = m_data[(m_k - 1) / PER];
            drivingEBUS = m_drive[(m_k - 1) / PER];
        end else begin
            EBUS        = 6'($urandom);
            drivingEBUS = 1'($urandom);
        end
    end

    // launch one operation, optionally pulse start at cycles pa/pb, and
    // return the cycle (after E0) in which done was seen
    task automatic do_op(input logic ld, input logic [2:0] sel, input int pa, input int pb,
                         output int dc, output int ldc);
        int c;
        dc  = 0;
        ldc = 0;
        @(negedge clk); #1;
        start   = 1'b1;
        opLoad  = ld;
        loadSel = sel;
        @(negedge clk); #1;
        start = 1'b0;
        c = 1;
        while (c < 300) begin
            if (diagLoadFunc06X) ldc++;
            if (done) begin
                dc = c;
                break;
            end
            @(negedge clk); #1;
            c++;
            start = (c == pa || c == pb);
            if (start) begin
                opLoad  = 1'($urandom);
                loadSel = 3'($urandom);
            end
        end
        start = 1'b0;
        chk("done_within_budget", 64'(dc != 0), 64'd1);
    endtask

    task automatic set_data_random(input int drop_any);
        for (int j = 0; j < 8; j++) begin
            cur_data[j]  = 6'($urandom_range(0, 63));
            cur_drive[j] = (drop_any != 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
        end
    endtask

    initial begin : main
        int dc;
        int ldc;
        int pa;
        logic       kind;
        logic [2:0] sel;
        rst_n       = 1'b0;
        start       = 1'b0;
        opLoad      = 1'b0;
        loadSel     = 3'd0;
        EBUS        = 6'd0;
        drivingEBUS = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cur_data[j]  = 6'd0;
            cur_drive[j] = 1'b1;
        end

        // reset
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_snapshot", 64'(snapshot), 64'd0);
        chk("reset_diag", 64'(diag), 64'd0);
        chk("reset_strobes", 64'({diagLoadFunc06X, diagReadFunc13X}), 64'd0);
        rst_n = 1'b1;

        // sweep with EBUS = i*9 mod 64
        for (int j = 0; j < 8; j++) begin
            cur_data[j]  = 6'((j * 9) % 64);
            cur_drive[j] = 1'b1;
        end
        do_op(1'b0, 3'd0, 0, 0, dc, ldc);
        chk("sweep_done_cycle", 64'(dc), 64'd33);
        chk("sweep_snapshot_literal", 64'(snapshot),
            64'({6'd63, 6'd54, 6'd45, 6'd36, 6'd27, 6'd18, 6'd9, 6'd0}));
        chk("sweep_noresp", 64'(noResp), 64'd0);

        // load subfunction 5
        do_op(1'b1, 3'd5, 0, 0, dc, ldc);
        chk("load_done_cycle", 64'(dc), 64'd5);
        chk("load_strobe_cycles", 64'(ldc), 64'd3);
        chk("load_diag", 64'(diag), 64'd5);
        chk("load_keeps_snapshot", 64'(snapshot),
            64'({6'd63, 6'd54, 6'd45, 6'd36, 6'd27, 6'd18, 6'd9, 6'd0}));

        // sweep with no response on subfunction 3
        set_data_random(0);
        cur_drive[3] = 1'b0;
        do_op(1'b0, 3'd0, 0, 0, dc, ldc);
        chk("noresp_sweep_cycle", 64'(dc), 64'd33);
        chk("noresp_set", 64'(noResp), 64'd1);
        chk("noresp_field3_zero", 64'(snapshot[23:18]), 64'd0);
        chk("noresp_field5", 64'(snapshot[35:30]), 64'(cur_data[5]));
        do_op(1'b1, 3'($urandom), 0, 0, dc, ldc);
        chk("noresp_cleared", 64'(noResp), 64'd0);

        // start pulses during a sweep are ignored; back-to-back restart
        set_data_random(1);
        do_op(1'b0, 3'd0, 5, 20, dc, ldc);
        chk("ignored_start_done_cycle", 64'(dc), 64'd33);
        set_data_random(1);
        do_op(1'b0, 3'd0, 0, 0, dc, ldc);
        chk("back_to_back_done_cycle", 64'(dc), 64'd33);

        // reset at cycle 14 of a sweep
        set_data_random(0);
        @(negedge clk); #1;
        start  = 1'b1;
        opLoad = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (13) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_noresp", 64'(noResp), 64'd0);
        chk("midreset_snapshot", 64'(snapshot), 64'd0);
        chk("midreset_diag", 64'(diag), 64'd0);
        chk("midreset_strobes", 64'({diagLoadFunc06X, diagReadFunc13X}), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        set_data_random(0);
        do_op(1'b0, 3'd0, 0, 0, dc, ldc);
        chk("post_reset_sweep_cycle", 64'(dc), 64'd33);

        // randomized operations
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            kind = 1'($urandom);
            sel  = 3'($urandom);
            set_data_random(1);
            pa = ($urandom_range(0, 1) != 0) ? $urandom_range(2, LOAD_LEN - 1) : 0;
            do_op(kind, sel, pa, 0, dc, ldc);
            chk("random_done_cycle", 64'(dc), 64'(kind ? LOAD_LEN : SWEEP_LEN));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
